// File: rtl/icache_ctrl_pkg.sv
// Shared constants and state encoding for the instruction cache controller.
package icache_ctrl_pkg;

    localparam int ICACHE_LINE_WORDS = 4;
    localparam int ICACHE_NUM_LINES  = 16;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IC_IDLE   = 2'd0,
        IC_REQ    = 2'd1,
        IC_REFILL = 2'd2
    } ic_state_e;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays for the direct-mapped cache: combinational read,
// per-word refill write, tag+valid install, and clear-all.
module icache_line_store
    import icache_ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int NUM_LINES  = ICACHE_NUM_LINES,
    parameter int TAGW       = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [$clog2(NUM_LINES)-1:0]  rd_index,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_off,
    output logic                          rd_valid,
    output logic [TAGW-1:0]               rd_tag,
    output logic [XLEN-1:0]               rd_word,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_LINES)-1:0]  wr_index,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_off,
    input  logic [XLEN-1:0]               wr_data,
    input  logic                          set_en,
    input  logic [TAGW-1:0]               set_tag,
    input  logic                          clear_all
);

    logic [NUM_LINES-1:0]                            valid;
    logic [NUM_LINES-1:0][TAGW-1:0]                  tags;
    logic [NUM_LINES-1:0][LINE_WORDS-1:0][XLEN-1:0]  data;

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_word  = data[rd_index][rd_off];

    // Valid bits: clear-all wins over an install on the same edge, so a
    // pending invalidate also kills the line that is just finishing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            valid <= '0;
        else if (clear_all)
            valid <= '0;
        else if (set_en)
            valid[wr_index] <= 1'b1;
    end

    // Tag and data payload need no reset; valid gates every use.
    always_ff @(posedge clk) begin
        if (wr_en)
            data[wr_index][wr_off] <= wr_data;
        if (set_en)
            tags[wr_index] <= set_tag;
    end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache: combinational lookup on the fetch port,
// single-line refill toward backing memory on a miss.
module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int NUM_LINES  = ICACHE_NUM_LINES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [XLEN-1:0] req_addr,
    input  logic            flush,
    input  logic            invalidate,
    output logic [XLEN-1:0] instruction,
    output logic            icache_stall,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count
);

    localparam int WOFF = $clog2(LINE_WORDS);
    localparam int IDXW = $clog2(NUM_LINES);
    localparam int LOW  = WOFF + 2;
    localparam int TAGW = XLEN - IDXW - LOW;

    ic_state_e       state;
    logic [WOFF-1:0] beat_cnt;
    logic            inv_pend;

    logic [WOFF-1:0] req_off;
    logic [IDXW-1:0] req_idx;
    logic [TAGW-1:0] req_tag;
    logic [IDXW-1:0] fill_idx;
    logic [TAGW-1:0] fill_tag;
    logic            rd_valid;
    logic [TAGW-1:0] rd_tag;
    logic [XLEN-1:0] rd_word;
    logic            hit;
    logic            fill_beat;
    logic            fill_last;
    logic            clear_all;
    logic            unused_bits;

    assign req_off  = req_addr[LOW-1:2];
    assign req_idx  = req_addr[LOW+IDXW-1:LOW];
    assign req_tag  = req_addr[XLEN-1:LOW+IDXW];
    assign fill_idx = mem_req_addr[LOW+IDXW-1:LOW];
    assign fill_tag = mem_req_addr[XLEN-1:LOW+IDXW];
    // flush needs no action: a refill always completes and the new PC is
    // simply looked up once the FSM is back in IDLE.
    assign unused_bits = ^{req_addr[1:0], mem_req_addr[LOW-1:0], flush};

    // Outputs are forced quiet while reset is held, independent of the clock.
    assign hit          = reset & req_valid & (state == IC_IDLE) & rd_valid & (rd_tag == req_tag);
    assign icache_stall = reset & ((req_valid & ~hit) | (state != IC_IDLE));
    assign instruction  = hit ? rd_word : NOP_INSTR;

    assign fill_beat = (state == IC_REFILL) & mem_resp_valid;
    assign fill_last = fill_beat & (beat_cnt == WOFF'(LINE_WORDS - 1));
    assign clear_all = ((state == IC_IDLE) & invalidate) | (fill_last & (inv_pend | invalidate));

    icache_line_store #(
        .XLEN(XLEN), .LINE_WORDS(LINE_WORDS), .NUM_LINES(NUM_LINES), .TAGW(TAGW)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .rd_index  (req_idx),
        .rd_off    (req_off),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_word   (rd_word),
        .wr_en     (fill_beat),
        .wr_index  (fill_idx),
        .wr_off    (beat_cnt),
        .wr_data   (mem_resp_data),
        .set_en    (fill_last),
        .set_tag   (fill_tag),
        .clear_all (clear_all)
    );

    // Refill FSM with registered request outputs and hit/miss counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IC_IDLE;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            beat_cnt      <= '0;
            inv_pend      <= 1'b0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            case (state)
                IC_IDLE: begin
                    if (hit) begin
                        hit_count <= hit_count + 32'd1;
                    end else if (req_valid) begin
                        miss_count    <= miss_count + 32'd1;
                        mem_req_addr  <= {req_addr[XLEN-1:LOW], {LOW{1'b0}}};
                        mem_req_valid <= 1'b1;
                        state         <= IC_REQ;
                    end
                end
                IC_REQ: begin
                    if (invalidate)
                        inv_pend <= 1'b1;
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        beat_cnt      <= '0;
                        state         <= IC_REFILL;
                    end
                end
                IC_REFILL: begin
                    if (invalidate)
                        inv_pend <= 1'b1;
                    if (mem_resp_valid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (fill_last) begin
                            inv_pend <= 1'b0;
                            state    <= IC_IDLE;
                        end
                    end
                end
                default: state <= IC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: behavioural backing memory with
// configurable request latency and beat gaps, table-driven fetches plus
// hand-built flush / invalidate / async-reset sequences.
module tb_icache_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        flush;
    logic        invalidate;
    logic [31:0] instruction;
    logic        icache_stall;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache_ctrl #(.XLEN(32), .LINE_WORDS(4), .NUM_LINES(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .flush          (flush),
        .invalidate     (invalidate),
        .instruction    (instruction),
        .icache_stall   (icache_stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int exp_hit  = 0;
    int exp_miss = 0;
    int m_wait = 0;   // cycles before memory raises ready
    int m_gap  = -1;  // beat index preceded by one idle cycle (-1 none)

    typedef struct {
        logic [31:0] instr;
        int          stall;
        string       nm;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [31:0] addr;
        int          wait_c;
        int          gap;
        int          stall;
        int          nmiss;
        logic [31:0] instr;
        string       nm;
    } vec_t;
    vec_t vt[10];

    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'h0000_00A0 + (a >> 2);
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'h0000_000F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Backing memory: ready after m_wait cycles, then LINE_WORDS beats in order.
    initial begin : mem_model
        bit          hs;
        int          beats_left;
        int          beat;
        int          ready_cnt;
        bit          gap_done;
        logic [31:0] base;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        beats_left = 0; beat = 0; ready_cnt = 0; gap_done = 0; base = '0;
        forever begin
            @(negedge clk);
            hs = mem_req_valid && mem_req_ready;
            @(posedge clk);
            #1;
            if (!reset) begin
                mem_req_ready  = 1'b0;
                mem_resp_valid = 1'b0;
                beats_left = 0; ready_cnt = 0;
                continue;
            end
            if (hs) begin
                beats_left = 4; beat = 0; gap_done = 0; ready_cnt = 0;
                base = mem_req_addr;
            end
            mem_resp_valid = 1'b0;
            if (beats_left > 0) begin
                if (m_gap == beat && !gap_done) begin
                    gap_done = 1;
                end else begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = memword(base + 32'(4 * beat));
                    beat++;
                    beats_left--;
                end
            end
            mem_req_ready = 1'b0;
            if (mem_req_valid && beats_left == 0 && !hs) begin
                if (ready_cnt >= m_wait) mem_req_ready = 1'b1;
                else ready_cnt++;
            end
        end
    end

    // One fetch from posedge+1 until the hit; optional redirect / invalidate
    // pulse after a given number of stalled cycles.
    task automatic fetch(input logic [31:0] a, input int exp_stall, input logic [31:0] exp_instr,
                         input int nmiss, input int redir_at, input logic [31:0] redir_addr,
                         input int inv_at, input string nm);
        sb_t         e;
        int          n;
        bit          addr_ok;
        bit          prev_pend;
        logic [31:0] prev_addr;
        e.instr = exp_instr; e.stall = exp_stall; e.nm = nm;
        sbq.push_back(e);
        exp_miss += nmiss;
        exp_hit++;
        req_valid = 1'b1; req_addr = a; flush = 1'b0;
        invalidate = (inv_at == 0);
        n = 0; addr_ok = 1; prev_pend = 0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (mem_req_valid && mem_req_addr !== line_of(req_addr)) addr_ok = 0;
            if (prev_pend && (!mem_req_valid || mem_req_addr !== prev_addr)) addr_ok = 0;
            prev_pend = mem_req_valid && !mem_req_ready;
            prev_addr = mem_req_addr;
            if (!icache_stall || n >= 100) break;
            n++;
            @(posedge clk);
            #1;
            invalidate = (n == inv_at);
            flush      = (n == redir_at);
            if (n == redir_at) req_addr = redir_addr;
        end
        e = sbq.pop_front();
        chk({e.nm, ".stall_cycles"}, 32'(n), 32'(e.stall));
        chk({e.nm, ".instr"}, instruction, e.instr);
        chk({e.nm, ".req_addr_stable"}, 32'(addr_ok), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; invalidate = 1'b0; flush = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin : test
        vt[0] = '{32'h000, 0, -1,  6, 1, memword(32'h000), "cold_0x0"};
        vt[1] = '{32'h004, 0, -1,  0, 0, memword(32'h004), "hit_0x4"};
        vt[2] = '{32'h008, 0, -1,  0, 0, memword(32'h008), "hit_0x8"};
        vt[3] = '{32'h00C, 0, -1,  0, 0, memword(32'h00C), "hit_0xC"};
        vt[4] = '{32'h014, 0, -1,  6, 1, memword(32'h014), "miss_0x14"};
        vt[5] = '{32'h010, 0, -1,  0, 0, memword(32'h010), "hit_0x10"};
        vt[6] = '{32'h100, 3,  2, 10, 1, memword(32'h100), "conflict_0x100"};
        vt[7] = '{32'h000, 0, -1,  6, 1, memword(32'h000), "remiss_0x0"};
        vt[8] = '{32'h108, 0, -1,  6, 1, memword(32'h108), "remiss_0x108"};
        vt[9] = '{32'h01C, 0, -1,  0, 0, memword(32'h01C), "hit_0x1C"};

        // Reset state, with a fetch presented while reset is low.
        reset = 1'b0; req_valid = 1'b1; req_addr = 32'h40; flush = 1'b0; invalidate = 1'b0;
        #2;
        chk("rst.stall", 32'(icache_stall), 32'd0);
        chk("rst.instr", instruction, NOP);
        chk("rst.mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst.mem_req_addr", mem_req_addr, 32'd0);
        chk("rst.hit_count", hit_count, 32'd0);
        chk("rst.miss_count", miss_count, 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            m_wait = vt[i].wait_c;
            m_gap  = vt[i].gap;
            fetch(vt[i].addr, vt[i].stall, vt[i].instr, vt[i].nmiss, -1, 32'h0, -1, vt[i].nm);
        end
        m_wait = 0; m_gap = -1;
        chk("tbl.hit_count", hit_count, 32'(exp_hit));
        chk("tbl.miss_count", miss_count, 32'(exp_miss));

        // Redirect to 0x40 during the 0x200 refill: both lines end up resident.
        fetch(32'h200, 12, memword(32'h040), 2, 3, 32'h040, -1, "flush_redirect");
        for (int w = 0; w < 4; w++)
            fetch(32'h200 + 32'(4 * w), 0, memword(32'h200 + 32'(4 * w)), 0, -1, 32'h0, -1, "flush_line_word");
        fetch(32'h044, 0, memword(32'h044), 0, -1, 32'h0, -1, "flush_new_line");

        // Invalidate during refill: fresh line dead on return, so two refills.
        fetch(32'h300, 12, memword(32'h300), 2, -1, 32'h0, 3, "inv_in_refill");
        fetch(32'h044, 6, memword(32'h044), 1, -1, 32'h0, -1, "inv_all_lines");

        // Invalidate in IDLE: same-cycle lookup still hits, next one misses.
        fetch(32'h048, 0, memword(32'h048), 0, -1, 32'h0, 0, "inv_idle_hit");
        fetch(32'h048, 6, memword(32'h048), 1, -1, 32'h0, -1, "inv_idle_after");
        chk("inv.hit_count", hit_count, 32'(exp_hit));
        chk("inv.miss_count", miss_count, 32'(exp_miss));

        // Async reset between edges in the middle of a refill of 0x500.
        req_valid = 1'b1; req_addr = 32'h500;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("arst.mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("arst.stall", 32'(icache_stall), 32'd0);
        chk("arst.instr", instruction, NOP);
        chk("arst.hit_count", hit_count, 32'd0);
        chk("arst.miss_count", miss_count, 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_hit = 0; exp_miss = 0;
        fetch(32'h048, 6, memword(32'h048), 1, -1, 32'h0, -1, "arst_refetch");
        chk("arst.post_hit_count", hit_count, 32'(exp_hit));
        chk("arst.post_miss_count", miss_count, 32'(exp_miss));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
